// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Purpose  : Multi-cycle instruction control FSM. Steps each instruction
//            through FETCH / LOADIR / DECODE / EXEC / MEM / WB and issues
//            one-cycle strobes to the datapath.
//            Halts on an illegal opcode.
//            Counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic [5:0]  opcode_i,
    input  logic        beq_taken_i,
    output logic        inst_rd_o,
    output logic        ir_ld_o,
    output logic        pc_incr_o,
    output logic        pc_ld_o,
    output logic        reg_rd_o,
    output logic        reg_wr_o,
    output logic        dc_rd_o,
    output logic        dc_wr_o,
    output logic        halted_o,
    output logic        illegal_o,
    output logic [2:0]  state_o,
    output logic [15:0] inst_count_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Only legal opcodes (1..7) are ever captured, so three bits suffice.
    localparam logic [2:0] C_OP_LOAD  = 3'd5;
    localparam logic [2:0] C_OP_STORE = 3'd6;
    localparam logic [2:0] C_OP_BEQ   = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  opc_q;
    logic [2:0]  opc_next_w;
    logic        retire_w;
    logic        illegal_set_w;
    logic        op_illegal_w;

    logic        inst_rd_q, ir_ld_q, pc_incr_q, reg_rd_q, reg_wr_q;
    logic        dc_rd_q, dc_wr_q, halted_q, illegal_q, beq_exec_q;
    logic [15:0] inst_count_q;

    // Opcode is only meaningful while in DECODE; elsewhere the captured copy
    // steers the EXEC/MEM/WB paths.
    assign op_illegal_w  = (opcode_i == 6'd0) || (opcode_i > 6'd7);
    assign opc_next_w    = (state_q == S_DECODE) ? opcode_i[2:0] : opc_q;
    assign illegal_set_w = (state_q == S_DECODE) && op_illegal_w;

    // Next-state and retire decision from the current state and captured opcode.
    always_comb begin
        state_d  = state_q;
        retire_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH:  state_d = S_LOADIR;
            S_LOADIR: state_d = S_DECODE;
            S_DECODE: begin
                state_d = op_illegal_w ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (opc_q == C_OP_BEQ) begin
                    retire_w = 1'b1;
                    state_d  = run_i ? S_FETCH : S_IDLE;
                end else if ((opc_q == C_OP_LOAD) || (opc_q == C_OP_STORE)) begin
                    state_d = S_MEM;
                end else if (opc_q != 3'd0) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (opc_q == C_OP_STORE) begin
                    retire_w = 1'b1;
                    state_d  = run_i ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retire_w = 1'b1;
                state_d  = run_i ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, opcode capture, counter and registered Moore strobes.
    // Strobes are decoded from the next state so each one is aligned with
    // the cycle in which the FSM occupies the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            opc_q        <= 3'd0;
            inst_rd_q    <= 1'b0;
            ir_ld_q      <= 1'b0;
            pc_incr_q    <= 1'b0;
            reg_rd_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            dc_rd_q      <= 1'b0;
            dc_wr_q      <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            beq_exec_q   <= 1'b0;
            inst_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_DECODE) && !op_illegal_w) begin
                opc_q <= opcode_i[2:0];
            end
            inst_rd_q    <= (state_d == S_FETCH);
            ir_ld_q      <= (state_d == S_LOADIR);
            pc_incr_q    <= (state_d == S_LOADIR);
            reg_rd_q     <= (state_d == S_DECODE);
            reg_wr_q     <= (state_d == S_WB);
            dc_rd_q      <= (state_d == S_MEM) && (opc_next_w == C_OP_LOAD);
            dc_wr_q      <= (state_d == S_MEM) && (opc_next_w == C_OP_STORE);
            halted_q     <= (state_d == S_HALT);
            illegal_q    <= illegal_q | illegal_set_w;
            beq_exec_q   <= (state_d == S_EXEC) && (opc_next_w == C_OP_BEQ);
            inst_count_q <= inst_count_q + {15'd0, retire_w};
        end
    end

    // The branch outcome only becomes valid during EXEC, so pc_ld is the
    // registered "beq in EXEC" qualifier gated by the comparator result.
    assign pc_ld_o      = beq_exec_q & beq_taken_i;
    assign inst_rd_o    = inst_rd_q;
    assign ir_ld_o      = ir_ld_q;
    assign pc_incr_o    = pc_incr_q;
    assign reg_rd_o     = reg_rd_q;
    assign reg_wr_o     = reg_wr_q;
    assign dc_rd_o      = dc_rd_q;
    assign dc_wr_o      = dc_wr_q;
    assign halted_o     = halted_q;
    assign illegal_o    = illegal_q;
    assign state_o      = state_q;
    assign inst_count_o = inst_count_q;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer. The expected trace of
//            each instruction is built from its class and latency; random
//            opcodes, branch outcomes and run levels drive the sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    localparam logic [7:0] C_SB_IRD = 8'h80;
    localparam logic [7:0] C_SB_IRL = 8'h40;
    localparam logic [7:0] C_SB_PCI = 8'h20;
    localparam logic [7:0] C_SB_PCL = 8'h10;
    localparam logic [7:0] C_SB_RRD = 8'h08;
    localparam logic [7:0] C_SB_RWR = 8'h04;
    localparam logic [7:0] C_SB_DRD = 8'h02;
    localparam logic [7:0] C_SB_DWR = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_i;
    logic [5:0]  opcode_i;
    logic        beq_taken_i;
    logic        inst_rd_o, ir_ld_o, pc_incr_o, pc_ld_o;
    logic        reg_rd_o, reg_wr_o, dc_rd_o, dc_wr_o;
    logic        halted_o, illegal_o;
    logic [2:0]  state_o;
    logic [15:0] inst_count_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_count;
    logic        model_illegal;
    logic        in_idle;

    control_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .opcode_i     (opcode_i),
        .beq_taken_i  (beq_taken_i),
        .inst_rd_o    (inst_rd_o),
        .ir_ld_o      (ir_ld_o),
        .pc_incr_o    (pc_incr_o),
        .pc_ld_o      (pc_ld_o),
        .reg_rd_o     (reg_rd_o),
        .reg_wr_o     (reg_wr_o),
        .dc_rd_o      (dc_rd_o),
        .dc_wr_o      (dc_wr_o),
        .halted_o     (halted_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o),
        .inst_count_o (inst_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] strobes();
        return {inst_rd_o, ir_ld_o, pc_incr_o, pc_ld_o,
                reg_rd_o, reg_wr_o, dc_rd_o, dc_wr_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Every output against the model while the outputs are stable.
    task automatic check_all(input string tag, input logic [7:0] exp_sb, input logic [2:0] exp_st);
        check({tag, ".strobes"}, {24'd0, strobes()}, {24'd0, exp_sb});
        check({tag, ".state"},   {29'd0, state_o}, {29'd0, exp_st});
        check({tag, ".halted"},  {31'd0, halted_o}, {31'd0, exp_st == 3'd7});
        check({tag, ".illegal"}, {31'd0, illegal_o}, {31'd0, model_illegal});
        check({tag, ".count"},   {16'd0, inst_count_o}, {16'd0, model_count});
    endtask

    // One clock cycle: inputs applied just after the rising edge, outputs
    // compared at the falling edge.
    task automatic step(input logic r, input logic [5:0] opc, input logic bt,
                        input logic [7:0] exp_sb, input logic [2:0] exp_st);
        @(posedge clk);
        #1;
        run_i       = r;
        opcode_i    = opc;
        beq_taken_i = bt;
        @(negedge clk);
        check_all("step", exp_sb, exp_st);
    endtask

    function automatic logic [5:0] junk6();
        return 6'($urandom);
    endfunction

    function automatic logic junk1();
        return 1'($urandom);
    endfunction

    // Expected trace of one instruction, derived from its class:
    // ALU 5 cycles, load 6, store 5, beq 4; illegal stops after DECODE.
    // run only matters in the final cycle, so the middle cycles get noise.
    task automatic run_instr(input logic [5:0] opc, input logic taken, input logic run_after);
        if (in_idle) step(1'b1, junk6(), junk1(), 8'h00, 3'd0);
        in_idle = 1'b0;
        step(junk1(), junk6(), junk1(), C_SB_IRD, 3'd1);
        step(junk1(), junk6(), junk1(), C_SB_IRL | C_SB_PCI, 3'd2);
        step(junk1(), opc, junk1(), C_SB_RRD, 3'd3);
        if (opc == 6'd0 || opc > 6'd7) begin
            model_illegal = 1'b1;
            return;
        end
        if (opc == 6'd7) begin
            step(run_after, junk6(), taken, taken ? C_SB_PCL : 8'h00, 3'd4);
        end else if (opc == 6'd5) begin
            step(junk1(), junk6(), junk1(), 8'h00, 3'd4);
            step(junk1(), junk6(), junk1(), C_SB_DRD, 3'd5);
            step(run_after, junk6(), junk1(), C_SB_RWR, 3'd6);
        end else if (opc == 6'd6) begin
            step(junk1(), junk6(), junk1(), 8'h00, 3'd4);
            step(run_after, junk6(), junk1(), C_SB_DWR, 3'd5);
        end else begin
            step(junk1(), junk6(), junk1(), 8'h00, 3'd4);
            step(run_after, junk6(), junk1(), C_SB_RWR, 3'd6);
        end
        model_count = model_count + 16'd1;
        if (!run_after) begin
            repeat ($urandom_range(1, 3)) step(1'b0, junk6(), junk1(), 8'h00, 3'd0);
            in_idle = 1'b1;
        end
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear
    // before the next rising edge.
    task automatic apply_reset();
        #1;
        run_i = 1'b0;
        rst_n = 1'b0;
        #1;
        model_count   = 16'd0;
        model_illegal = 1'b0;
        check_all("reset", 8'h00, 3'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        in_idle = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        run_i       = 1'b0;
        opcode_i    = 6'd0;
        beq_taken_i = 1'b0;
        model_count   = 16'd0;
        model_illegal = 1'b0;
        in_idle       = 1'b1;
        repeat (2) @(negedge clk);
        check_all("por", 8'h00, 3'd0);
        rst_n = 1'b1;

        // Directed: ALU, load, store, beq taken / not taken, load with run dropped.
        run_instr(6'd1, 1'b0, 1'b1);
        run_instr(6'd5, 1'b0, 1'b1);
        run_instr(6'd6, 1'b0, 1'b1);
        run_instr(6'd7, 1'b1, 1'b1);
        run_instr(6'd7, 1'b0, 1'b1);
        run_instr(6'd5, 1'b0, 1'b0);
        run_instr(6'd2, 1'b0, 1'b1);

        // Randomised legal instruction stream.
        for (int i = 0; i < 60; i++) begin
            run_instr(6'($urandom_range(1, 7)), junk1(), ($urandom_range(0, 3) != 0));
        end

        // Illegal opcode 0: halt, run ignored for 20 cycles.
        run_instr(6'd0, 1'b0, 1'b1);
        repeat (20) step(1'b1, junk6(), junk1(), 8'h00, 3'd7);
        apply_reset();

        // Illegal opcode above 7.
        run_instr(6'd8, 1'b0, 1'b1);
        repeat (20) step(1'b1, junk6(), junk1(), 8'h00, 3'd7);
        apply_reset();
        run_instr(6'($urandom_range(8, 63)), 1'b0, 1'b1);
        repeat (5) step(1'b1, junk6(), junk1(), 8'h00, 3'd7);
        apply_reset();

        // Counter wrap: deposit a value near the top instead of 65k retires.
        dut.inst_count_q = 16'hFFFE;
        model_count      = 16'hFFFE;
        run_instr(6'd7, 1'b0, 1'b1);
        run_instr(6'd3, 1'b0, 1'b1);
        run_instr(6'd6, 1'b0, 1'b1);

        // Reset in the middle of a taken-branch EXEC cycle.
        step(1'b1, junk6(), junk1(), C_SB_IRD, 3'd1);
        step(1'b1, junk6(), junk1(), C_SB_IRL | C_SB_PCI, 3'd2);
        step(1'b1, 6'd7, junk1(), C_SB_RRD, 3'd3);
        @(posedge clk);
        #1;
        beq_taken_i = 1'b1;
        #1;
        check_all("exec_pre_reset", C_SB_PCL, 3'd4);
        apply_reset();
        step(1'b0, junk6(), junk1(), 8'h00, 3'd0);
        run_instr(6'd4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on simulation length.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock; the only clock in the block.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; enables instruction sequencing.
REQ-005 opcode  input  6  opcode field of the instruction register; stable from the cycle after ir_ld.
REQ-006 beq_taken  input  1  equality result of the branch comparator; valid in EXEC.
REQ-007 inst_rd  output  1  instruction cache read strobe.
REQ-008 ir_ld  output  1  instruction register load strobe.
REQ-009 pc_incr  output  1  program counter increment strobe.
REQ-010 pc_ld  output  1  program counter load (branch) strobe.
REQ-011 reg_rd  output  1  register file read strobe.
REQ-012 reg_wr  output  1  register file write-back strobe.
REQ-013 dc_rd  output  1  data cache read strobe.
REQ-014 dc_wr  output  1  data cache write strobe.
REQ-015 halted  output  1  high while in HALT.
REQ-016 illegal  output  1  sticky flag; the opcode that caused HALT was illegal.
REQ-017 state  output  3  current state encoding: IDLE=0, FETCH=1, LOADIR=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
REQ-018 inst_count  output  16  number of retired instructions.

Function
REQ-019 All strobe outputs SHALL be registered, Moore-decoded from the state, and high for exactly one clk cycle per assertion, so downstream posedge-triggered stages see exactly one rising edge.
REQ-020 IDLE: all strobes low; go to FETCH when run=1, otherwise stay in IDLE.
REQ-021 FETCH: inst_rd=1; next state LOADIR.
REQ-022 LOADIR: ir_ld=1 and pc_incr=1; next state DECODE.
REQ-023 DECODE: reg_rd=1; opcode is sampled in this state; opcode 0 or opcode>7 goes to HALT with illegal set, otherwise next state EXEC.
REQ-024 EXEC, opcode 1-4 (ALU): no strobe; next state WB.
REQ-025 EXEC, opcode 5 (load) or 6 (store): no strobe; next state MEM.
REQ-026 EXEC, opcode 7 (beq): pc_ld=1 iff beq_taken=1; the instruction retires; next state FETCH if run=1, else IDLE.
REQ-027 MEM, opcode 5: dc_rd=1; next state WB.
REQ-028 MEM, opcode 6: dc_wr=1; the instruction retires; next state FETCH if run=1, else IDLE.
REQ-029 WB: reg_wr=1; the instruction retires; next state FETCH if run=1, else IDLE.
REQ-030 Latency per instruction: ALU 5 cycles, load 6 cycles, store 5 cycles, beq 4 cycles, measured from FETCH entry to the next FETCH entry.
REQ-031 inst_count SHALL increment by 1 on the last cycle of each retired instruction and wrap from 16'hFFFF to 0 without a flag.
REQ-032 Deasserting run mid-instruction SHALL NOT abort the instruction; it completes and the sequencer then enters IDLE.
REQ-033 pc_incr and pc_ld SHALL never be high in the same cycle, and dc_rd and dc_wr SHALL never be high in the same cycle.
REQ-034 HALT: all strobes low, halted=1; HALT is left only by reset, and run is ignored.
REQ-035 inst_count SHALL NOT count an illegal instruction.
REQ-036 opcode and beq_taken SHALL be ignored in every state except DECODE (opcode) and EXEC (beq_taken) respectively; the opcode captured in DECODE selects the EXEC, MEM and WB paths.

Reset
REQ-037 rst_n=0 SHALL immediately force state=IDLE, all strobes 0, halted=0, illegal=0 and inst_count=0, independent of clk.
REQ-038 Reset asserted mid-instruction SHALL abandon that instruction, with no further strobes and no count increment; after rst_n rises, sequencing restarts from IDLE on the first clk edge with run=1.

Verification
REQ-039 Reset, then run=1 with opcode=1: the strobe sequence inst_rd, ir_ld+pc_incr, reg_rd, (none), reg_wr across 5 cycles, and inst_count goes 0->1.
REQ-040 opcode=5, then opcode=6: the load asserts dc_rd in cycle 5 and reg_wr in cycle 6; the store asserts dc_wr in cycle 5 with no reg_wr; inst_count=2.
REQ-041 opcode=7 with beq_taken=1, then with beq_taken=0: pc_ld pulses once in EXEC for the first only; each takes 4 cycles.
REQ-042 opcode=0 (and separately opcode=8): DECODE->HALT, halted=1, illegal=1, inst_count unchanged, no strobes for 20 cycles with run=1.
REQ-043 Drop run during MEM of a load: reg_wr still pulses, then state=IDLE; asserting run resumes at FETCH.
REQ-044 Assert rst_n=0 asynchronously in the middle of EXEC: all outputs clear before the next clk edge; preload inst_count to 16'hFFFF via retires and verify the wrap to 0.
